// File: rtl/loop_replay_buffer.sv
// loop_replay_buffer: spots a short backward conditional branch that keeps
// being taken, captures the loop body into a small buffer, then replays the
// body on its own while holding the front end. A mispredict on the closing
// branch ends replay and redirects fetch to the loop exit with a flush.
module loop_replay_buffer #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int CONF_THRESH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] curr_PC,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] immediate,
  input  logic            mispredict,
  output logic            block_signal,
  output logic            out_valid,
  output logic [31:0]     out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic            flush,
  output logic [XLEN-1:0] new_pc
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAIN,
    S_CAPTURE,
    S_REPLAY,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [XLEN-1:0] r_brPc;
  logic [XLEN-1:0] r_tgt;
  logic [IW-1:0]   r_lastIdx;
  logic [3:0]      r_cnt;
  logic [IW-1:0]   r_wptr;
  logic [IW-1:0]   r_rptr;
  logic [31:0]     r_buf [DEPTH];

  logic [XLEN-1:0] w_len;
  logic            w_qualify;
  logic [XLEN-1:0] w_tgt;
  logic [IW-1:0]   w_lastIdx;
  logic            w_inRange;
  logic [XLEN-1:0] w_expPc;
  logic [IW-1:0]   w_rptrAdv;
  logic            w_load;
  logic            w_bufWe;
  logic [3:0]      w_cntNext;
  logic [IW-1:0]   w_wptrNext;
  logic [IW-1:0]   w_rptrNext;

  // Body length is -imm + 1; the last buffer index (len - 1) is just -imm,
  // and only its low IW bits matter because a qualifying len never exceeds DEPTH.
  assign w_len     = XLEN'(0) - immediate + XLEN'(1);
  assign w_qualify = (instruction[6:0] == 7'b1100011) && immediate[XLEN-1] &&
                     (w_len <= XLEN'(DEPTH));
  assign w_tgt     = curr_PC + {immediate[XLEN-3:0], 2'b00};
  assign w_lastIdx = IW'(0) - immediate[IW-1:0];
  assign w_inRange = (curr_PC >= r_tgt) && (curr_PC <= r_brPc);
  // The capture write pointer doubles as the expected-PC offset from tgt.
  assign w_expPc   = r_tgt + XLEN'({r_wptr, 2'b00});
  assign w_rptrAdv = (r_rptr == r_lastIdx) ? '0 : r_rptr + IW'(1);

  // State register for the detect/capture/replay sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and datapath control; mispredict outranks every other event.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_bufWe     = 1'b0;
    w_cntNext   = r_cnt;
    w_wptrNext  = r_wptr;
    w_rptrNext  = r_rptr;
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_qualify) begin
          w_load      = 1'b1;
          w_cntNext   = 4'd1;
          w_wptrNext  = '0;
          w_stateNext = (CONF_THRESH == 1) ? S_CAPTURE : S_TRAIN;
        end
      end
      S_TRAIN: begin
        if (mispredict) begin
          w_stateNext = S_IDLE;
        end else if (in_valid) begin
          if (curr_PC == r_brPc) begin
            w_cntNext = r_cnt + 4'd1;
            if (w_cntNext == 4'(CONF_THRESH)) begin
              w_stateNext = S_CAPTURE;
              w_wptrNext  = '0;
            end
          end else if (!w_inRange) begin
            w_stateNext = S_IDLE;
          end
        end
      end
      S_CAPTURE: begin
        if (mispredict) begin
          w_stateNext = S_IDLE;
        end else if (in_valid) begin
          if (curr_PC == w_expPc) begin
            w_bufWe = 1'b1;
            if (curr_PC == r_brPc) begin
              w_stateNext = S_REPLAY;
              w_rptrNext  = '0;
            end else begin
              w_wptrNext = r_wptr + IW'(1);
            end
          end else begin
            w_stateNext = S_IDLE;
          end
        end
      end
      S_REPLAY: begin
        if (mispredict) begin
          w_stateNext = S_FLUSH;
        end else begin
          w_rptrNext = w_rptrAdv;
        end
      end
      S_FLUSH: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Loop descriptor, confidence count and buffer pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_brPc    <= '0;
      r_tgt     <= '0;
      r_lastIdx <= '0;
      r_cnt     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      if (w_load) begin
        r_brPc    <= curr_PC;
        r_tgt     <= w_tgt;
        r_lastIdx <= w_lastIdx;
      end
      r_cnt  <= w_cntNext;
      r_wptr <= w_wptrNext;
      r_rptr <= w_rptrNext;
    end
  end

  // Loop body storage; contents are meaningless until a capture completes.
  always_ff @(posedge clk) begin
    if (w_bufWe) begin
      r_buf[r_wptr] <= instruction;
    end
  end

  // Registered outputs, computed from the state being entered so replay data
  // and the flush pulse appear right after the edge that triggers them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_signal    <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
      flush           <= 1'b0;
      new_pc          <= '0;
    end else begin
      block_signal <= (w_stateNext == S_REPLAY);
      out_valid    <= (w_stateNext == S_REPLAY);
      if (w_stateNext == S_REPLAY) begin
        out_instruction <= r_buf[w_rptrNext];
        out_pc          <= r_tgt + XLEN'({w_rptrNext, 2'b00});
      end else begin
        out_instruction <= '0;
        out_pc          <= '0;
      end
      flush  <= (w_stateNext == S_FLUSH);
      new_pc <= (w_stateNext == S_FLUSH) ? (r_brPc + XLEN'(4)) : '0;
    end
  end

endmodule

// File: tb/tb_loop_replay_buffer.sv
// tb_loop_replay_buffer: directed and randomized loops driven into the replay
// buffer, with an event-level reference model feeding a scoreboard queue.
module tb_loop_replay_buffer;

  localparam int XLEN        = 32;
  localparam int DEPTH       = 8;
  localparam int CONF_THRESH = 2;

  localparam int M_IDLE    = 0;
  localparam int M_TRAIN   = 1;
  localparam int M_CAPTURE = 2;
  localparam int M_REPLAY  = 3;
  localparam int M_FLUSH   = 4;

  typedef struct {
    int          cyc;
    bit          isFlush;
    logic [31:0] instr;
    logic [31:0] pc;
  } evt_t;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [XLEN-1:0] curr_PC;
  logic [31:0]     instruction;
  logic [XLEN-1:0] immediate;
  logic            mispredict;
  logic            block_signal;
  logic            out_valid;
  logic [31:0]     out_instruction;
  logic [XLEN-1:0] out_pc;
  logic            flush;
  logic [XLEN-1:0] new_pc;

  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleCount  = 0;
  bit   inReset     = 1'b1;
  evt_t expQ [$];

  int          mMode;
  logic [31:0] mBr;
  logic [31:0] mTgt;
  int          mLen;
  int          mCnt;
  int          mIdx;
  logic [31:0] mBody [$];

  logic [31:0] loopBody [16];

  loop_replay_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CONF_THRESH(CONF_THRESH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .curr_PC(curr_PC),
    .instruction(instruction), .immediate(immediate), .mispredict(mispredict),
    .block_signal(block_signal), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .flush(flush), .new_pc(new_pc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so expected events can be pinned to a cycle.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  function automatic bit isLoopBranch(input logic [31:0] ins, input logic [31:0] imm);
    longint bodyLen;
    bodyLen = 64'sd1 - longint'($signed(imm));
    return (ins[6:0] == 7'b1100011) && ($signed(imm) < 0) && (bodyLen <= DEPTH);
  endfunction

  task automatic pushEvt(input bit isFl, input logic [31:0] ins, input logic [31:0] pc);
    evt_t e;
    e.cyc     = cycleCount + 1;
    e.isFlush = isFl;
    e.instr   = ins;
    e.pc      = pc;
    expQ.push_back(e);
  endtask

  task automatic modelReset();
    mMode = M_IDLE;
    mCnt  = 0;
    mIdx  = 0;
    mBody.delete();
  endtask

  // Reference behaviour: what the block should emit after the edge that
  // samples this cycle's inputs.
  task automatic modelStep(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] imm, input bit mp);
    case (mMode)
      M_IDLE: begin
        if (v && isLoopBranch(ins, imm)) begin
          mBr  = pc;
          mTgt = pc + imm * 32'd4;
          mLen = int'(64'sd1 - longint'($signed(imm)));
          mCnt = 1;
          mBody.delete();
          mMode = (CONF_THRESH == 1) ? M_CAPTURE : M_TRAIN;
        end
      end
      M_TRAIN: begin
        if (mp) mMode = M_IDLE;
        else if (v) begin
          if (pc == mBr) begin
            mCnt++;
            if (mCnt >= CONF_THRESH) begin
              mMode = M_CAPTURE;
              mBody.delete();
            end
          end else if (pc < mTgt || pc > mBr) begin
            mMode = M_IDLE;
          end
        end
      end
      M_CAPTURE: begin
        if (mp) mMode = M_IDLE;
        else if (v) begin
          if (pc == mTgt + 32'(mBody.size()) * 32'd4) begin
            mBody.push_back(ins);
            if (pc == mBr) begin
              mMode = M_REPLAY;
              mIdx  = 0;
              pushEvt(1'b0, mBody[0], mTgt);
            end
          end else begin
            mMode = M_IDLE;
          end
        end
      end
      M_REPLAY: begin
        if (mp) begin
          mMode = M_FLUSH;
          pushEvt(1'b1, 32'h0, mBr + 32'd4);
        end else begin
          mIdx = (mIdx + 1) % mLen;
          pushEvt(1'b0, mBody[mIdx], mTgt + 32'(mIdx) * 32'd4);
        end
      end
      default: mMode = M_IDLE;
    endcase
  endtask

  // Drive one cycle of inputs just after a rising edge and advance the model.
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] imm, input bit mp);
    @(posedge clk);
    #1;
    in_valid    = v;
    curr_PC     = pc;
    instruction = ins;
    immediate   = imm;
    mispredict  = mp;
    modelStep(v, pc, ins, imm, mp);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, $urandom(), $urandom(), $urandom(), 1'b0);
  endtask

  task automatic mispredictCycle();
    applyStimulus(1'b0, $urandom(), $urandom(), $urandom(), 1'b1);
  endtask

  task automatic replayCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), 1'b0);
    end
  endtask

  task automatic makeBody(input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = $urandom();
      w[6:0] = (i == len - 1) ? 7'b1100011 : 7'b0010011;
      loopBody[i] = w;
    end
  endtask

  task automatic setBasicBody();
    loopBody[0] = 32'h0000_0013;
    loopBody[1] = 32'h0000_0014;
    loopBody[2] = 32'h0000_0015;
    loopBody[3] = 32'hFC00_0AE3;
  endtask

  task automatic runLoop(input logic [31:0] base, input int len, input int iters,
                         input int gapPct, input int mispPct);
    logic [31:0] imm;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < len; i++) begin
        if (int'($urandom_range(0, 99)) < gapPct) begin
          repeat ($urandom_range(1, 2)) idleCycle();
        end
        if (int'($urandom_range(0, 99)) < mispPct) mispredictCycle();
        imm = (i == len - 1) ? 32'(-(len - 1)) : ((gapPct == 0) ? 32'h0 : $urandom());
        applyStimulus(1'b1, base + 32'(4 * i), loopBody[i], imm, 1'b0);
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " block_signal"}, 32'(block_signal), 32'h0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, " out_instruction"}, out_instruction, 32'h0);
    checkOutput({tag, " out_pc"}, out_pc, 32'h0);
    checkOutput({tag, " flush"}, 32'(flush), 32'h0);
    checkOutput({tag, " new_pc"}, new_pc, 32'h0);
  endtask

  // Drop reset between clock edges and confirm outputs clear without an edge.
  task automatic resetMidway();
    #1;
    inReset = 1'b1;
    expQ.delete();
    in_valid   = 1'b0;
    mispredict = 1'b0;
    reset      = 1'b0;
    #1;
    checkAllZero("async reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset();
    inReset = 1'b0;
  endtask

  // Scoreboard monitor: pops an expected event whenever the block presents
  // replay data or a flush, and flags outputs that are missing or spurious.
  always @(negedge clk) begin
    evt_t e;
    if (!inReset) begin
      if (out_valid || flush) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious out_valid", 32'(out_valid), 32'h0);
          checkOutput("spurious flush", 32'(flush), 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("event cycle", 32'(cycleCount), 32'(e.cyc));
          checkOutput("out_valid", 32'(out_valid), 32'(!e.isFlush));
          checkOutput("block_signal", 32'(block_signal), 32'(!e.isFlush));
          checkOutput("flush", 32'(flush), 32'(e.isFlush));
          if (e.isFlush) begin
            checkOutput("new_pc", new_pc, e.pc);
          end else begin
            checkOutput("out_instruction", out_instruction, e.instr);
            checkOutput("out_pc", out_pc, e.pc);
          end
        end
      end else begin
        checkOutput("idle block_signal", 32'(block_signal), 32'h0);
        if (expQ.size() != 0 && expQ[0].cyc <= cycleCount) begin
          e = expQ.pop_front();
          if (e.isFlush) checkOutput("missed flush", 32'(flush), 32'h1);
          else checkOutput("missed out_valid", 32'(out_valid), 32'h1);
        end
      end
    end
  end

  // Main sequence: reset, directed scenarios, then randomized loops.
  initial begin
    logic [31:0] base;
    int          len;
    reset       = 1'b1;
    in_valid    = 1'b0;
    curr_PC     = '0;
    instruction = '0;
    immediate   = '0;
    mispredict  = 1'b0;
    modelReset();
    #1;
    reset = 1'b0;
    #2;
    checkAllZero("reset value");
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b1;
    inReset = 1'b0;

    $display("[TB] basic replay and mispredict exit");
    setBasicBody();
    runLoop(32'h100, 4, 3, 0, 0);
    replayCycles(9);
    mispredictCycle();
    repeat (3) idleCycle();

    $display("[TB] oversize loop");
    makeBody(9);
    runLoop(32'h100, 9, 4, 0, 0);
    repeat (3) idleCycle();

    $display("[TB] capture abort then fresh loop");
    setBasicBody();
    runLoop(32'h100, 4, 2, 0, 0);
    applyStimulus(1'b1, 32'h100, loopBody[0], 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h104, loopBody[1], 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h200, 32'h0000_0013, 32'h0, 1'b0);
    makeBody(4);
    runLoop(32'h110, 4, 3, 0, 0);
    replayCycles(6);
    mispredictCycle();
    repeat (2) idleCycle();

    $display("[TB] gapped capture");
    makeBody(4);
    runLoop(32'h300, 4, 2, 0, 0);
    applyStimulus(1'b1, 32'h300, loopBody[0], 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h304, loopBody[1], 32'h0, 1'b0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b1, 32'h308, loopBody[2], 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h30C, loopBody[3], 32'hFFFF_FFFD, 1'b0);
    replayCycles(8);
    mispredictCycle();
    repeat (2) idleCycle();

    $display("[TB] reset during replay");
    setBasicBody();
    runLoop(32'h100, 4, 3, 0, 0);
    replayCycles(3);
    resetMidway();
    runLoop(32'h100, 4, 1, 0, 0);
    repeat (2) idleCycle();
    runLoop(32'h100, 4, 2, 0, 0);
    replayCycles(5);
    mispredictCycle();
    repeat (2) idleCycle();

    $display("[TB] randomized loops");
    for (int s = 0; s < 40; s++) begin
      len  = int'($urandom_range(2, 10));
      base = 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
      makeBody(len);
      runLoop(base, len, int'($urandom_range(1, 4)), 15, 3);
      replayCycles(int'($urandom_range(0, 12)));
      mispredictCycle();
      repeat ($urandom_range(0, 2)) idleCycle();
    end

    repeat (4) idleCycle();
    @(negedge clk);
    @(negedge clk);
    checkOutput("pending expected events", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/loop_replay_buffer.md
# loop_replay_buffer

Parametrised loop detector and instruction replay buffer in the fetch stage. It watches the fetched instruction stream for a short backward conditional branch that repeats, then captures the loop body into an internal buffer. After capture it replays the body itself while holding the front-end fetch. A mispredict on the loop-closing branch ends replay, and the block then redirects fetch to the loop exit with a one-cycle flush.

## Interface
- `XLEN`, 32: PC and immediate width.
- `DEPTH`, 8: maximum loop body length in instructions; must be a power of two ≥ 2.
- `CONF_THRESH`, 2: number of consecutive taken observations of the same branch before capture starts; range 1–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `in_valid` in 1: `curr_PC`, `instruction` and `immediate` are valid this cycle.
- `curr_PC` in XLEN: PC of the fetched instruction.
- `instruction` in 32: fetched instruction word.
- `immediate` in XLEN: decoded branch offset in instruction units, signed; target = `curr_PC` + `immediate`·4.
- `mispredict` in 1: the loop-closing branch resolved not-taken.
- `block_signal` out 1: front-end fetch must stall; the block is supplying instructions.
- `out_valid` out 1: `out_instruction` and `out_pc` are valid.
- `out_instruction` out 32: replayed instruction.
- `out_pc` out XLEN: PC of the replayed instruction.
- `flush` out 1: one-cycle pipeline flush request.
- `new_pc` out XLEN: fetch redirect target, valid while `flush` = 1.

## Operation
- A qualifying branch meets all three conditions: `instruction[6:0]` = 7'b1100011, `immediate` is negative, and body length `len` = −`immediate` + 1 ≤ `DEPTH`. `len` is computed in XLEN bits. `immediate` = 0 never qualifies.
- The block stores `br_pc`, `tgt` = `br_pc` + `immediate`·4, `len` and a confidence count `cnt`.
- **IDLE**: a valid qualifying branch loads `br_pc`, `tgt` and `len`, sets `cnt` = 1, and moves to TRAIN. If `CONF_THRESH` = 1 it moves directly to CAPTURE instead.
- **TRAIN**:
  - A valid instruction with PC in [`tgt`, `br_pc`] keeps the state.
  - A valid instruction at `br_pc` increments `cnt`. When `cnt` reaches `CONF_THRESH`, the state moves to CAPTURE.
  - A valid PC outside the range returns the state to IDLE.
- **CAPTURE**:
  - The expected PC starts at `tgt` and advances by 4 on each valid input.
  - Each matching input is written to `buf[(PC − tgt)>>2]`.
  - A write at `br_pc` moves the state to REPLAY with `rptr` = 0.
  - Any mismatch returns the state to IDLE and discards the partial capture.
- **REPLAY**:
  - Outputs: `block_signal` = 1, `out_valid` = 1, `out_instruction` = `buf[rptr]`, `out_pc` = `tgt` + 4·`rptr`.
  - `rptr` increments each cycle and wraps to 0 after `len`−1.
  - Inputs other than `mispredict` are ignored.
- **FLUSH**: lasts exactly one cycle, with `flush` = 1, `new_pc` = `br_pc` + 4, `block_signal` = 0 and `out_valid` = 0. The state then goes to IDLE.
- `mispredict` has priority over every other event:
  - In REPLAY it moves the state to FLUSH.
  - In TRAIN or CAPTURE it moves the state to IDLE with no flush.
  - In IDLE or FLUSH it is ignored.
- When `in_valid` = 0 in TRAIN or CAPTURE, the state holds and the expected PC does not advance.

## Timing
- Reset values for all outputs are 0: `block_signal`, `out_valid`, `flush`, `out_instruction`, `out_pc` and `new_pc`. Internal state after reset is IDLE, `cnt` = 0, `rptr` = 0.
- All outputs are registered.
- REPLAY begins at the edge that samples the captured branch. `block_signal` and the first replayed instruction (`buf[0]`) appear in the next cycle.
- Replay throughput is one instruction per cycle with no bubble at wrap.
- A `mispredict` sampled at edge N in REPLAY gives `flush` = 1 in cycle N+1. It also gives `block_signal` = 0 from cycle N+1.
- A new qualifying branch can be accepted in the cycle after FLUSH.
- Deasserting `reset` in any state, including mid-REPLAY or during FLUSH, returns the block to IDLE with all outputs 0 and the buffer contents don't-care.

## Test plan
- **Basic replay** (DEPTH=8, CONF_THRESH=2): three iterations of 0x100:0x13, 0x104:0x14, 0x108:0x15, 0x10C:0xFC000AE3 (imm −3).
  - Required: `block_signal` = 1 after the third 0x10C.
  - `out_instruction`/`out_pc` repeat 0x13/0x100, 0x14/0x104, 0x15/0x108, 0xFC000AE3/0x10C.
- **Mispredict exit**: from the basic replay, assert `mispredict` for one cycle.
  - Required: exactly one cycle of `flush` = 1 with `new_pc` = 0x110.
  - `block_signal` and `out_valid` = 0 from that cycle onward.
- **Oversize loop**: branch at 0x120 with imm −8 (len 9 > DEPTH), repeated 4 times -> `block_signal` stays 0.
- **Capture abort**: two iterations of the 0x100 loop, then PC 0x200 during CAPTURE -> IDLE, no replay.
  - A subsequent three clean iterations of the 0x110–0x11C loop then replay with `out_pc` 0x110–0x11C.
- **Gapped input**: `in_valid` low for 2 cycles mid-CAPTURE -> capture resumes, replay contents identical to the gapless case.
- **Reset mid-replay**: assert `reset` = 0 during REPLAY -> all outputs 0 immediately without waiting for a clock edge. After release, no replay until a fresh detection.
